alu_mc: RTL

Multi-cycle, parametrised successor to the combinational project ALU. Accepts one operation per start/ready handshake, executes single-cycle ops in one clock and integer multiply as an iterative shift-add over DATA_WIDTH clocks, and returns a registered result with a one-cycle done pulse. It sits between the control unit and the register file in the multi-cycle processor datapath.

---
 rtl/alu_mc_pkg.sv | 15 +
 rtl/alu_mc_mul_iter.sv | 43 ++++
 rtl/alu_mc.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared widths and opcode values for the multi-cycle ALU
// Holds default DATA_WIDTH/OPRN_WIDTH and the opcode numbers used by alu_mc.
package alu_mc_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int OPRN_WIDTH_DEF = 6;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_MUL = 3;
    localparam int OP_SRL = 4;
    localparam int OP_SLL = 5;
    localparam int OP_AND = 6;
    localparam int OP_OR  = 7;
    localparam int OP_NOR = 8;
    localparam int OP_SLT = 9;
endpackage

// File: rtl/alu_mc_mul_iter.sv
// mul_iter: iterative shift-add multiplier datapath, one partial product per step
// Ports: clk, rst_n (sync active-low), load (capture a/b, clear acc/count),
//        step (one iteration), a/b operands, acc_next (acc after this step),
//        last (this step is iteration W).
module mul_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_next,
    output logic         last
);
    localparam int CW = $clog2(W);
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;
    // The final product is taken from acc_next so it can be registered on the last step edge.
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign last     = count == CW'(W - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
            count  <= count + CW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, single-cycle ops plus DATA_WIDTH-cycle shift-add multiply
// Ports: CLK, RST (sync active-low), start/oprn/op1/op2 request (taken when ready),
//        ready (idle), done (one-cycle pulse), result (registered, held),
//        zero (result == 0), err (unsupported opcode, registered with done).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OPRN_WIDTH = OPRN_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [OPRN_WIDTH-1:0] oprn,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  err
);
    localparam int SW = $clog2(DATA_WIDTH);
    typedef enum logic {IDLE, MUL} state_t;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] alu_res, res_n, acc_next;
    logic                  alu_err, err_n, done_n, load, step, last, big;
    logic [SW-1:0]         shamt;
    // DATA_WIDTH is a power of two, so any set bit above the shift field means op2 >= DATA_WIDTH.
    assign big   = |op2[DATA_WIDTH-1:SW];
    assign shamt = op2[SW-1:0];
    assign ready = state == IDLE;
    assign zero  = result == '0;
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (oprn)
            OPRN_WIDTH'(OP_ADD): alu_res = op1 + op2;
            OPRN_WIDTH'(OP_SUB): alu_res = op1 - op2;
            OPRN_WIDTH'(OP_SRL): alu_res = big ? '0 : op1 >> shamt;
            OPRN_WIDTH'(OP_SLL): alu_res = big ? '0 : op1 << shamt;
            OPRN_WIDTH'(OP_AND): alu_res = op1 & op2;
            OPRN_WIDTH'(OP_OR):  alu_res = op1 | op2;
            OPRN_WIDTH'(OP_NOR): alu_res = ~(op1 | op2);
            OPRN_WIDTH'(OP_SLT): alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            default:             alu_err = 1'b1;
        endcase
    end
    always_comb begin
        state_n = state;
        res_n   = result;
        err_n   = err;
        done_n  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        if (state == IDLE) begin
            if (start && oprn == OPRN_WIDTH'(OP_MUL)) begin
                load    = 1'b1;
                state_n = MUL;
            end else if (start) begin
                res_n  = alu_res;
                err_n  = alu_err;
                done_n = 1'b1;
            end
        end else begin
            step = 1'b1;
            if (last) begin
                res_n   = acc_next;
                err_n   = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            result <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            result <= res_n;
            err    <= err_n;
            done   <= done_n;
        end
    end
    mul_iter #(.W(DATA_WIDTH)) u_mul (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (load),
        .step     (step),
        .a        (op1),
        .b        (op2),
        .acc_next (acc_next),
        .last     (last)
    );
endmodule
